// File: rtl/jk_cmd_driver_if.sv
// ----------------------------------------------------------------------------
// jk_cmd_driver_if
// Command handshake between an upstream command source and jk_cmd_driver.
//   cmd_valid : command present (source -> driver)
//   cmd_op    : 2-bit command, 00 hold / 01 reset / 10 set / 11 toggle
//   cmd_ready : driver can accept a command this cycle (driver -> source)
// master modport is the command source, slave modport is the driver.
// ----------------------------------------------------------------------------
interface jk_cmd_driver_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_op,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_driver.sv
// ----------------------------------------------------------------------------
// jk_cmd_driver
// Upstream command stage for a single JK flip-flop cell. Brings the cell out
// of reset to a known q=0, then for each accepted command drives J/K for one
// cycle, lets the cell settle for one cycle, and compares the cell's q/qbar
// against an internal reference model. Mismatches set a sticky err flag and
// bump a saturating error counter; every completed command bumps cmd_cnt.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cmd               : command handshake (slave side: valid/op in, ready out)
//   j, k              : registered J/K drive to the cell
//   ff_rst            : registered synchronous reset to the cell
//   q_in, qbar_in     : cell outputs
//   model_q           : expected q after the most recently accepted command
//   busy              : high in every state except IDLE
//   err               : sticky mismatch flag (cleared only by rst)
//   err_cnt, cmd_cnt  : saturating failed-check / completed-command counts
// CNT_W must be at least 2.
// ----------------------------------------------------------------------------
module jk_cmd_driver #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    jk_cmd_driver_if.slave    cmd,
    output logic              j,
    output logic              k,
    output logic              ff_rst,
    input  logic              q_in,
    input  logic              qbar_in,
    output logic              model_q,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  cmd_cnt
);

    localparam logic [2:0] ST_INIT_RST = 3'd0;
    localparam logic [2:0] ST_INIT_CLR = 3'd1;
    localparam logic [2:0] ST_IDLE     = 3'd2;
    localparam logic [2:0] ST_DRIVE    = 3'd3;
    localparam logic [2:0] ST_CHECK    = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_r,   state_s;
    logic             j_r,       j_s;
    logic             k_r,       k_s;
    logic             ff_rst_r,  ff_rst_s;
    logic             ready_r,   ready_s;
    logic             busy_r,    busy_s;
    logic             model_q_r, model_q_s;
    logic             err_r,     err_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic [CNT_W-1:0] cmd_cnt_r, cmd_cnt_s;

    // Reference model of the JK cell's q after applying a command.
    function automatic logic model_next(input logic cur, input logic [1:0] op);
        logic nxt;
        case (op)
            2'b00:   nxt = cur;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~cur;
            default: nxt = 1'b0;
        endcase
        return nxt;
    endfunction

    // Cell response check; the case-inequality makes any X/Z count as a
    // mismatch in simulation.
    function automatic logic check_mismatch(input logic q, input logic qb,
                                            input logic mq);
        return (q !== mq) || (qb !== ~mq);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Next-state and next-output computation for the command sequencer.
    always_comb begin
        state_s   = state_r;
        j_s       = 1'b0;
        k_s       = 1'b0;
        ff_rst_s  = 1'b0;
        ready_s   = 1'b0;
        busy_s    = 1'b1;
        model_q_s = model_q_r;
        err_s     = err_r;
        err_cnt_s = err_cnt_r;
        cmd_cnt_s = cmd_cnt_r;
        case (state_r)
            ST_INIT_RST: begin
                // Release the cell reset but keep K asserted for one more
                // cycle so the cell is cleared by J/K as well.
                state_s = ST_INIT_CLR;
                k_s     = 1'b1;
            end
            ST_INIT_CLR: begin
                state_s = ST_IDLE;
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    state_s   = ST_DRIVE;
                    j_s       = cmd.cmd_op[1];
                    k_s       = cmd.cmd_op[0];
                    model_q_s = model_next(model_q_r, cmd.cmd_op);
                end else begin
                    ready_s = 1'b1;
                    busy_s  = 1'b0;
                end
            end
            ST_DRIVE: begin
                // J/K return to hold so the cell keeps the driven value
                // while it is being checked.
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                state_s   = ST_IDLE;
                ready_s   = 1'b1;
                busy_s    = 1'b0;
                cmd_cnt_s = sat_inc(cmd_cnt_r);
                if (check_mismatch(q_in, qbar_in, model_q_r)) begin
                    err_s     = 1'b1;
                    err_cnt_s = sat_inc(err_cnt_r);
                end else begin
                    err_s     = err_r;
                    err_cnt_s = err_cnt_r;
                end
            end
            default: begin
                // Unreachable encoding: restart the cell initialisation.
                state_s  = ST_INIT_RST;
                ff_rst_s = 1'b1;
                k_s      = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_INIT_RST;
            j_r       <= 1'b0;
            k_r       <= 1'b1;
            ff_rst_r  <= 1'b1;
            ready_r   <= 1'b0;
            busy_r    <= 1'b1;
            model_q_r <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= {CNT_W{1'b0}};
            cmd_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            j_r       <= j_s;
            k_r       <= k_s;
            ff_rst_r  <= ff_rst_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
            model_q_r <= model_q_s;
            err_r     <= err_s;
            err_cnt_r <= err_cnt_s;
            cmd_cnt_r <= cmd_cnt_s;
        end
    end

    assign cmd.cmd_ready = ready_r;
    assign j             = j_r;
    assign k             = k_r;
    assign ff_rst        = ff_rst_r;
    assign model_q       = model_q_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign err_cnt       = err_cnt_r;
    assign cmd_cnt       = cmd_cnt_r;

endmodule

// File: tb/tb_jk_cmd_driver.sv
// ----------------------------------------------------------------------------
// tb_jk_cmd_driver
// Drives jk_cmd_driver (CNT_W=8) attached to a behavioural JK cell, plus a
// second instance (CNT_W=2) whose q input is stuck at 1. Expected results are
// pushed to a scoreboard queue at command acceptance and popped when the
// command completes.
// ----------------------------------------------------------------------------
module tb_jk_cmd_driver;

    typedef struct {
        logic       model;
        logic       err;
        logic [7:0] ecnt;
        logic [7:0] ccnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // DUT 1 signals
    jk_cmd_driver_if cmd_if ();
    logic       j, k, ff_rst, q_in, qbar_in, model_q, busy, err;
    logic [7:0] err_cnt, cmd_cnt;

    // Behavioural JK cell and fault forcing
    logic cell_q;
    logic fq_en = 1'b0, fq = 1'b0, fqb_en = 1'b0, fqb = 1'b0;

    // DUT 2 signals (CNT_W=2, q stuck at 1)
    jk_cmd_driver_if cmd2_if ();
    logic       j2, k2, ff_rst2, model_q2, busy2, err2;
    logic [1:0] err_cnt2, cmd_cnt2;

    // Bench reference state
    exp_t sb[$];
    exp_t sb2[$];
    logic       exp_model = 1'b0;
    logic       exp_err = 1'b0;
    logic [7:0] exp_ecnt = 8'd0;
    logic [7:0] exp_ccnt = 8'd0;
    int  last_acc = 0;
    bit  have_last = 1'b0;

    jk_cmd_driver #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd(cmd_if),
        .j(j), .k(k), .ff_rst(ff_rst),
        .q_in(q_in), .qbar_in(qbar_in),
        .model_q(model_q), .busy(busy), .err(err),
        .err_cnt(err_cnt), .cmd_cnt(cmd_cnt)
    );

    jk_cmd_driver #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd(cmd2_if),
        .j(j2), .k(k2), .ff_rst(ff_rst2),
        .q_in(1'b1), .qbar_in(1'b0),
        .model_q(model_q2), .busy(busy2), .err(err2),
        .err_cnt(err_cnt2), .cmd_cnt(cmd_cnt2)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure acceptance spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Golden JK cell with synchronous reset.
    always @(posedge clk) begin
        if (ff_rst === 1'b1) begin
            cell_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   cell_q <= 1'b0;
                2'b10:   cell_q <= 1'b1;
                2'b11:   cell_q <= ~cell_q;
                default: cell_q <= cell_q;
            endcase
        end
    end

    assign q_in    = fq_en  ? fq  : cell_q;
    assign qbar_in = fqb_en ? fqb : ~cell_q;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_step(input logic cur, input logic [1:0] op);
        if (op == 2'b01) return 1'b0;
        if (op == 2'b10) return 1'b1;
        if (op == 2'b11) return ~cur;
        return cur;
    endfunction

    task automatic check_reset_vals();
        check_val("rst_ff_rst", ff_rst, 1);
        check_val("rst_jk", {j, k}, 2'b01);
        check_val("rst_ready", cmd_if.cmd_ready, 0);
        check_val("rst_busy", busy, 1);
        check_val("rst_model", model_q, 0);
        check_val("rst_err", err, 0);
        check_val("rst_err_cnt", err_cnt, 0);
        check_val("rst_cmd_cnt", cmd_cnt, 0);
    endtask

    // Called at a negedge with rst high; releases rst and walks the INIT cycles.
    task automatic init_seq();
        rst = 1'b0;
        check_val("c0_ff_rst", ff_rst, 1);
        check_val("c0_jk", {j, k}, 2'b01);
        @(negedge clk);
        check_val("c1_ff_rst", ff_rst, 0);
        check_val("c1_jk", {j, k}, 2'b01);
        check_val("c1_ready", cmd_if.cmd_ready, 0);
        @(negedge clk);
        check_val("c2_ready", cmd_if.cmd_ready, 1);
        check_val("c2_busy", busy, 0);
        check_val("c2_jk", {j, k}, 2'b00);
        check_val("c2_q", q_in, 0);
        check_val("c2_qbar", qbar_in, 1);
        check_val("c2_err", err, 0);
        check_val("c2_cmd_cnt", cmd_cnt, 0);
    endtask

    // fault: 0 none, 1 force q_in=0 in CHECK, 2 force q_in=qbar_in=1 in CHECK.
    // Leaves cmd_valid high on return; the caller drops it or issues the next.
    task automatic do_cmd(input logic [1:0] op, input int fault, input bit chk_gap);
        exp_t e;
        exp_t g;
        int   waited;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        waited = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            check_val("ready_timeout", 0, 1);
            cmd_if.cmd_valid = 1'b0;
        end else begin
            if (chk_gap && have_last) check_val("accept_gap", cyc - last_acc, 3);
            last_acc  = cyc;
            have_last = 1'b1;
            exp_model = model_step(exp_model, op);
            if (fault != 0) begin
                exp_err = 1'b1;
                if (exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'd1;
            end
            if (exp_ccnt != 8'hFF) exp_ccnt = exp_ccnt + 8'd1;
            e.model = exp_model;
            e.err   = exp_err;
            e.ecnt  = exp_ecnt;
            e.ccnt  = exp_ccnt;
            sb.push_back(e);
            @(negedge clk);                       // DRIVE
            check_val("drive_jk", {j, k}, op);
            check_val("drive_ready", cmd_if.cmd_ready, 0);
            check_val("drive_busy", busy, 1);
            cmd_if.cmd_op = ~op;                  // must not matter any more
            @(negedge clk);                       // CHECK
            check_val("check_jk", {j, k}, 2'b00);
            check_val("check_ready", cmd_if.cmd_ready, 0);
            if (fault == 1) begin
                fq_en = 1'b1; fq = 1'b0;
            end else if (fault == 2) begin
                fq_en = 1'b1; fq = 1'b1; fqb_en = 1'b1; fqb = 1'b1;
            end
            @(negedge clk);                       // back in IDLE
            fq_en  = 1'b0;
            fqb_en = 1'b0;
            cmd_if.cmd_op = op;
            g = sb.pop_front();
            check_val("model_q", model_q, g.model);
            check_val("cell_q", cell_q, g.model);
            check_val("err", err, g.err);
            check_val("err_cnt", err_cnt, g.ecnt);
            check_val("cmd_cnt", cmd_cnt, g.ccnt);
            check_val("idle_ready", cmd_if.cmd_ready, 1);
        end
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq [5];
        exp_t e2;
        exp_t g2;
        int   waited;
        seq[0] = 2'b10; seq[1] = 2'b00; seq[2] = 2'b11; seq[3] = 2'b11; seq[4] = 2'b01;

        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_op     = 2'b00;
        cmd2_if.cmd_valid = 1'b0;
        cmd2_if.cmd_op    = 2'b00;
        rst = 1'b1;
        // valid during reset must be ignored
        repeat (2) @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b10;
        @(negedge clk);
        check_reset_vals();
        cmd_if.cmd_valid = 1'b0;
        init_seq();

        // Back-to-back commands with cmd_valid held high
        for (int i = 0; i < 5; i++) do_cmd(seq[i], 0, 1'b1);
        cmd_if.cmd_valid = 1'b0;
        have_last = 1'b0;
        check_val("seq_cmd_cnt", cmd_cnt, 5);
        @(negedge clk);

        // q forced low during CHECK of a set, then a correct command
        do_cmd(2'b10, 1, 1'b0);
        do_cmd(2'b01, 0, 1'b0);
        // q and qbar both forced high during CHECK of a set
        do_cmd(2'b10, 2, 1'b0);
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);

        // rst asserted during DRIVE of a toggle
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b11;
        @(negedge clk);
        check_val("pre_rst_jk", {j, k}, 2'b11);
        cmd_if.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        exp_model = 1'b0; exp_err = 1'b0; exp_ecnt = 8'd0; exp_ccnt = 8'd0;
        init_seq();
        check_val("post_rst_cell_q", cell_q, 0);
        check_val("post_rst_cmd_cnt", cmd_cnt, 0);

        // Narrow counters, q stuck at 1, reset commands always mismatch
        for (int n = 1; n <= 5; n++) begin
            cmd2_if.cmd_valid = 1'b1;
            cmd2_if.cmd_op    = 2'b01;
            waited = 0;
            while (cmd2_if.cmd_ready !== 1'b1 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (waited >= 20) begin
                check_val("ready2_timeout", 0, 1);
            end else begin
                e2.model = 1'b0;
                e2.err   = 1'b1;
                e2.ecnt  = (n > 3) ? 8'd3 : 8'(n);
                e2.ccnt  = (n > 3) ? 8'd3 : 8'(n);
                sb2.push_back(e2);
                @(negedge clk);
                cmd2_if.cmd_valid = 1'b0;
                repeat (2) @(negedge clk);
                g2 = sb2.pop_front();
                check_val("sat_model_q", model_q2, g2.model);
                check_val("sat_err", err2, g2.err);
                check_val("sat_err_cnt", err_cnt2, g2.ecnt);
                check_val("sat_cmd_cnt", cmd_cnt2, g2.ccnt);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_cmd_driver.md
Name: jk_cmd_driver

Overview:
- Upstream command stage for a single JK flip-flop cell.
- Accepts abstract commands (hold/reset/set/toggle) over a valid/ready handshake and translates each one into a one-cycle J/K drive.
- Generates the cell's reset and checks the cell's q/qbar response one cycle later against an internal reference model.
- Flags mismatches (sticky error plus counters) so a bank of JK cells can be driven and self-checked by one instance each.

Parameters:
CNT_W, 8, width of cmd_cnt and err_cnt; both saturate at 2^CNT_W-1.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_op  input  2  00 hold, 01 reset-to-0, 10 set-to-1, 11 toggle.
cmd_ready  output  1  driver can accept a command this cycle.
j  output  1  registered J drive to the JK cell.
k  output  1  registered K drive to the JK cell.
ff_rst  output  1  registered synchronous reset to the JK cell.
q_in  input  1  q from the JK cell.
qbar_in  input  1  qbar from the JK cell.
model_q  output  1  expected q after the most recently accepted command.
busy  output  1  high in every state except IDLE.
err  output  1  sticky mismatch flag.
err_cnt  output  CNT_W  number of failed checks, saturating.
cmd_cnt  output  CNT_W  number of completed commands, saturating.

Behaviour:
- All outputs are registered. rst overrides everything on the clock edge.
- Reset values:
  - state=INIT_RST
  - ff_rst=1, j=0, k=1
  - cmd_ready=0, busy=1
  - model_q=0, err=0, err_cnt=0, cmd_cnt=0
- States: INIT_RST, INIT_CLR, IDLE, DRIVE, CHECK.
- INIT_RST (1 cycle after rst deasserts):
  - ff_rst=1, j/k=01.
  - Next state: INIT_CLR with ff_rst=0, j/k=01.
- INIT_CLR (1 cycle):
  - Forces the cell's qbar to a defined value (q=0, qbar=1).
  - Next state: IDLE with j/k=00.
  - The first cmd_ready=1 occurs 2 cycles after rst deasserts.
- IDLE:
  - cmd_ready=1, j/k=00.
  - On cmd_valid=1 at an edge, the command is accepted:
    - j/k are loaded as {j,k}=cmd_op.
    - model_q is updated: 00 keep, 01 to 0, 10 to 1, 11 to ~model_q.
    - cmd_ready goes to 0 and the next state is DRIVE.
  - cmd_op is sampled only at acceptance and may change afterwards.
- DRIVE (1 cycle):
  - j/k are held at the command value; the cell samples them at the closing edge.
  - Next state: CHECK with j/k=00, so the cell holds its value.
- CHECK (1 cycle):
  - q_in/qbar_in are compared at the closing edge.
  - Mismatch condition: q_in != model_q, or qbar_in != ~model_q. Any X/Z on either input counts as a mismatch.
  - On mismatch: err is set to 1 and err_cnt increments, saturating.
  - cmd_cnt increments regardless of the result, saturating.
  - Next state: IDLE with cmd_ready=1.
- Throughput is one command per 3 cycles (accept, DRIVE, CHECK). cmd_ready is never high in DRIVE or CHECK, so cmd_valid there is ignored. The upstream source holds cmd_valid until it sees ready.
- The hold command (00) still runs a full DRIVE/CHECK, which allows periodic state verification.
- Saturation: at all-ones, cmd_cnt and err_cnt stay at all-ones. err remains 1 until rst.
- rst mid-operation (DRIVE/CHECK): the command is abandoned and not counted, and the reset values apply. The cell is re-reset via the INIT sequence.
- cmd_valid during rst or INIT is ignored and nothing is accepted.

Test Plan:
- Release rst at cycle 0 with the golden JK cell attached:
  - ff_rst=1 for cycle 0, j/k=01 for cycles 0-1.
  - cmd_ready=1 first in cycle 2.
  - Cell shows q=0, qbar=1.
  - err=0, counts=0.
- Commands 10, 00, 11, 11, 01 back-to-back with cmd_valid held high:
  - Each is accepted 3 cycles apart.
  - model_q sequence is 1, 1, 0, 1, 0 and matches q_in.
  - cmd_cnt=5, err=0.
- Bench forces q_in=0 during the CHECK of a set command:
  - err=1 and err_cnt=1 at the end of CHECK.
  - A following correct command leaves err=1 and err_cnt=1, with cmd_cnt advancing.
- Bench forces qbar_in=q_in=1 during the CHECK of a set command:
  - Mismatch detected: err_cnt increments.
- Assert rst for one cycle while in DRIVE of a toggle:
  - All outputs return to reset values and cmd_cnt stays 0.
  - The INIT sequence repeats, and the cell ends at q=0.
- CNT_W=2, 5 commands with q_in stuck at 1:
  - cmd_cnt=3 (saturated).
  - err_cnt saturates at 3 once 3 mismatches have occurred, and no wrap occurs.
